// File: rtl/sd_dsp_pkg.sv
`default_nettype none
// ============================================================================
// Module      : sd_dsp_pkg
// Description : Shared constants and helper functions for the sigma-delta
//               reconstruction and magnitude blocks.
// Revision    : 1.0 - initial release
// ============================================================================
package sd_dsp_pkg;

    // Default sample width and filter shift used across the DSP slice
    localparam int c_DEF_WIDTH = 16;
    localparam int c_DEF_GAIN  = 8;

    // Positive full-scale code for a signed sample of the given width
    function automatic int full_scale(input int width);
        return (1 << (width - 1)) - 1;
    endfunction

    // Leaky-integrator accumulator width: sample bits plus filter shift
    function automatic int acc_width(input int width, input int gain);
        return width + gain;
    endfunction

    // Full-scale code for the default 16-bit build
    localparam int c_FS_DEF = full_scale(c_DEF_WIDTH);

endpackage
`default_nettype wire

// File: rtl/sd_small_lpf.sv
`default_nettype none
// ============================================================================
// Module      : sd_small_lpf
// Description : Maps a 1-bit sigma-delta stream to +/- full scale and
//               reconstructs a signed WIDTH-bit sample with a first-order
//               leaky integrator (time constant 2^GAIN enabled cycles).
// Revision    : 1.0 - initial release
// ============================================================================
module sd_small_lpf
    import sd_dsp_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int GAIN  = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    en,
    input  logic                    i_bit,
    output logic signed [WIDTH-1:0] o_y
);

    localparam int                     c_ACC_W = acc_width(WIDTH, GAIN);
    localparam logic signed [WIDTH-1:0] c_POS  = WIDTH'(full_scale(WIDTH));
    localparam logic signed [WIDTH-1:0] c_NEG  = -c_POS;

    logic signed [WIDTH-1:0]   w_x;
    logic signed [c_ACC_W-1:0] w_x_ext;
    logic signed [c_ACC_W-1:0] w_leak;
    logic signed [c_ACC_W-1:0] w_acc_next;
    logic signed [c_ACC_W-1:0] r_acc;

    assign w_x     = i_bit ? c_POS : c_NEG;
    assign w_x_ext = {{GAIN{w_x[WIDTH-1]}}, w_x};

    // Upper slice of the accumulator is exactly acc >>> GAIN (floor), sign-extended back
    assign w_leak     = {{GAIN{r_acc[c_ACC_W-1]}}, r_acc[c_ACC_W-1:GAIN]};
    assign w_acc_next = r_acc + w_x_ext - w_leak;

    // Leaky integrator: acc <= acc + x - (acc >>> GAIN) on each enabled edge
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_acc <= '0;
        end else if (en) begin
            r_acc <= w_acc_next;
        end
    end

    assign o_y = r_acc[c_ACC_W-1:GAIN];

endmodule
`default_nettype wire

// File: rtl/sd_dual_magnitude.sv
`default_nettype none
// ============================================================================
// Module      : sd_dual_magnitude
// Description : Squared-magnitude estimate of a sine/cosine pair delivered as
//               two sigma-delta bitstreams: filter, square, sum, scale.
//               Optional macro SD_DUAL_MAG_PIPE_EN inserts a register stage
//               between the squares and the adder (latency 3 instead of 2).
// Revision    : 1.0 - initial release
// ============================================================================
module sd_dual_magnitude
    import sd_dsp_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int GAIN  = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             inSin,
    input  logic             inCos,
    output logic [WIDTH-1:0] out
);

    localparam int c_SQ_W  = 2 * WIDTH - 2;
    localparam int c_SUM_W = 2 * WIDTH - 1;

    logic signed [WIDTH-1:0]  w_ys;
    logic signed [WIDTH-1:0]  w_yc;
    logic signed [c_SQ_W-1:0] w_ys_ext;
    logic signed [c_SQ_W-1:0] w_yc_ext;
    logic [c_SQ_W-1:0]        w_sq_s;
    logic [c_SQ_W-1:0]        w_sq_c;
    logic [c_SQ_W-1:0]        r_sq_s;
    logic [c_SQ_W-1:0]        r_sq_c;
    logic [c_SQ_W-1:0]        w_add_s;
    logic [c_SQ_W-1:0]        w_add_c;
    logic [c_SUM_W-1:0]       w_sum;
    logic [WIDTH-1:0]         w_out;
    logic [WIDTH-1:0]         r_out;

    sd_small_lpf #(
        .WIDTH (WIDTH),
        .GAIN  (GAIN)
    ) u_lpf_sin (
        .clk   (clk),
        .rst   (rst),
        .en    (en),
        .i_bit (inSin),
        .o_y   (w_ys)
    );

    sd_small_lpf #(
        .WIDTH (WIDTH),
        .GAIN  (GAIN)
    ) u_lpf_cos (
        .clk   (clk),
        .rst   (rst),
        .en    (en),
        .i_bit (inCos),
        .o_y   (w_yc)
    );

    // |y| < 2^(WIDTH-1), so the square fits exactly in 2*WIDTH-2 bits
    assign w_ys_ext = {{(WIDTH-2){w_ys[WIDTH-1]}}, w_ys};
    assign w_yc_ext = {{(WIDTH-2){w_yc[WIDTH-1]}}, w_yc};
    assign w_sq_s   = w_ys_ext * w_ys_ext;
    assign w_sq_c   = w_yc_ext * w_yc_ext;

    // Square register stage
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sq_s <= '0;
            r_sq_c <= '0;
        end else if (en) begin
            r_sq_s <= w_sq_s;
            r_sq_c <= w_sq_c;
        end
    end

`ifdef SD_DUAL_MAG_PIPE_EN
    logic [c_SQ_W-1:0] r_sq2_s;
    logic [c_SQ_W-1:0] r_sq2_c;

    // Extra retiming stage between the squares and the adder
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sq2_s <= '0;
            r_sq2_c <= '0;
        end else if (en) begin
            r_sq2_s <= r_sq_s;
            r_sq2_c <= r_sq_c;
        end
    end

    assign w_add_s = r_sq2_s;
    assign w_add_c = r_sq2_c;
`else
    assign w_add_s = r_sq_s;
    assign w_add_c = r_sq_c;
`endif

    // Sum of two (2*WIDTH-2)-bit squares cannot overflow 2*WIDTH-1 bits;
    // the scaled result peaks at 2^WIDTH-4, so no saturation is needed
    assign w_sum = {1'b0, w_add_s} + {1'b0, w_add_c};
    assign w_out = WIDTH'(w_sum >> (WIDTH - 1));

    // Output register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_out <= '0;
        end else if (en) begin
            r_out <= w_out;
        end
    end

    assign out = r_out;

endmodule
`default_nettype wire

// File: tb/tb_sd_dual_magnitude.sv
`default_nettype none
// ============================================================================
// Module      : tb_sd_dual_magnitude
// Description : Self-checking bench for sd_dual_magnitude (WIDTH=16, GAIN=8).
//               Cycle-exact scoreboard plus vector table and hand sequences.
//               Honours SD_DUAL_MAG_PIPE_EN for the expected latency.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sd_dual_magnitude;

    localparam int W  = 16;
    localparam int G  = 8;
    localparam longint FS = 32767;
`ifdef SD_DUAL_MAG_PIPE_EN
    localparam int LAT = 3;
`else
    localparam int LAT = 2;
`endif

    logic         clk   = 1'b0;
    logic         rst   = 1'b1;
    logic         en    = 1'b0;
    logic         inSin = 1'b0;
    logic         inCos = 1'b0;
    logic [W-1:0] out;

    always #5 clk = ~clk;

    sd_dual_magnitude #(
        .WIDTH (W),
        .GAIN  (G)
    ) dut (
        .clk   (clk),
        .rst   (rst),
        .en    (en),
        .inSin (inSin),
        .inCos (inCos),
        .out   (out)
    );

    int     checks = 0;
    int     errors = 0;
    longint m_acc_s;
    longint m_acc_c;
    int     q[$];
    int     last_exp;

    typedef struct {
        int    ps;
        int    pc;
        int    cycles;
        int    lo;
        int    hi;
        string name;
    } vec_t;

    vec_t vecs[7];

    task automatic chk(input string name, input int act, input int lo, input int hi);
        checks++;
        if (act < lo || act > hi) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d..%0d at %0t", name, act, lo, hi, $time);
        end
    endtask

    task automatic model_reset();
        m_acc_s = 0;
        m_acc_c = 0;
        q.delete();
        for (int i = 0; i < LAT; i++) q.push_back(0);
        last_exp = 0;
    endtask

    // Drive one cycle; the model pushes its expectation, the oldest is compared
    task automatic step(input logic s, input logic c, input logic e);
        longint xs, xc, ys, yc;
        inSin = s;
        inCos = c;
        en    = e;
        @(posedge clk);
        #1;
        if (e) begin
            xs      = s ? FS : -FS;
            xc      = c ? FS : -FS;
            m_acc_s = m_acc_s + xs - (m_acc_s >>> G);
            m_acc_c = m_acc_c + xc - (m_acc_c >>> G);
            ys      = m_acc_s >>> G;
            yc      = m_acc_c >>> G;
            q.push_back(int'((ys * ys + yc * yc) >> (W - 1)));
            last_exp = q.pop_front();
        end
        chk("pipe", int'(out), last_exp, last_exp);
    endtask

    // Assert reset between clock edges and check the output clears at once
    task automatic async_reset(input string name);
        @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        chk(name, int'(out), 0, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
    endtask

    function automatic logic pat(input int p, input int k);
        if (p == 0) return 1'b0;
        if (p == 1) return 1'b1;
        return (k % 2 == 0);
    endfunction

    task automatic run_sweep();
        real x1s, x2s, x1c, x2c, us, uc, vs, vc, sum, mean;
        logic bs, bc;
        x1s = 0.0; x2s = 0.0; x1c = 0.0; x2c = 0.0;
        us = 0.0; uc = 0.0; sum = 0.0;
        async_reset("sweep_rst");
        for (int k = 0; k < 16384; k++) begin
            if (k % 64 == 0) begin
                us = (30000.0 / 32767.0) * $sin(2.0 * 3.14159265358979 * real'(k / 64) / 128.0);
                uc = (30000.0 / 32767.0) * $cos(2.0 * 3.14159265358979 * real'(k / 64) / 128.0);
            end
            bs  = (x2s >= 0.0);
            bc  = (x2c >= 0.0);
            vs  = bs ? 1.0 : -1.0;
            vc  = bc ? 1.0 : -1.0;
            x2s = x2s + 0.5 * (x1s - vs);
            x1s = x1s + 0.5 * (us - vs);
            x2c = x2c + 0.5 * (x1c - vc);
            x1c = x1c + 0.5 * (uc - vc);
            step(bs, bc, 1'b1);
            if (k >= 8192) sum = sum + $sqrt(real'(out) * 32768.0);
        end
        mean = sum / 8192.0;
        chk("sweep_mag", int'(mean), 29400, 30600);
    endtask

    initial begin
        vecs[0] = '{0, 0, 4096, 65532, 65532, "zeros_ramp"};
        vecs[1] = '{1, 1, 4096, 65532, 65532, "ones_full"};
        vecs[2] = '{1, 0, 4096, 65532, 65532, "opposite_full"};
        vecs[3] = '{1, 2, 4096, 32466, 33066, "sin1_cos_alt"};
        vecs[4] = '{2, 1, 4096, 32466, 33066, "sin_alt_cos1"};
        vecs[5] = '{2, 2, 4096, 0, 2, "both_alt"};
        vecs[6] = '{2, 0, 4096, 32466, 33066, "sin_alt_cos0"};

        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk("reset_state", int'(out), 0, 0);

        for (int v = 0; v < 7; v++) begin
            async_reset({vecs[v].name, "_rst"});
            for (int k = 0; k < vecs[v].cycles; k++)
                step(pat(vecs[v].ps, k), pat(vecs[v].pc, k), 1'b1);
            chk(vecs[v].name, int'(out), vecs[v].lo, vecs[v].hi);
        end

        // Enable gating: settle, freeze while inputs flip, then resume
        async_reset("en_rst");
        for (int k = 0; k < 4096; k++) step(1'b1, 1'b1, 1'b1);
        chk("en_settle", int'(out), 65532, 65532);
        for (int k = 0; k < 100; k++) step(1'b0, 1'b0, 1'b0);
        chk("en_hold", int'(out), 65532, 65532);
        for (int k = 0; k < LAT + 1; k++) step(1'b0, 1'b0, 1'b1);
        chk("en_resume", int'(out), 0, 65531);

        // Mid-stream asynchronous reset with a large output value present
        async_reset("async_mid");

        // Random bits with random enable gaps
        for (int k = 0; k < 2000; k++)
            step(1'($urandom % 2), 1'($urandom % 2), 1'(($urandom % 4) != 0));

        run_sweep();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/sd_dual_magnitude.md
# sd_dual_magnitude

Estimates the squared magnitude of a quadrature pair delivered as two 1-bit sigma-delta bitstreams (sine and cosine channels). Each stream is low-pass filtered back to a signed multi-bit value, then the two values are squared, summed and scaled to an unsigned WIDTH-bit result. It sits downstream of second-order sigma-delta modulators and feeds envelope/level-detection logic.

## Interface
- WIDTH, 16: width of the reconstructed samples and of `out`.
- GAIN, 8: filter shift (time constant 2^GAIN enabled cycles).
- clk  in  1  system clock, all state on rising edge.
- rst  in  1  reset, asynchronous, active-high; clears all state.
- en  in  1  clock enable; when low, all state holds.
- inSin  in  1  sine-channel sigma-delta bit.
- inCos  in  1  cosine-channel sigma-delta bit.
- out  out  WIDTH  unsigned squared magnitude.

## Operation
- Bit mapping per channel: 1 -> +(2^(WIDTH-1)-1), 0 -> -(2^(WIDTH-1)-1), as a signed WIDTH-bit value x.
- Per-channel leaky integrator:
  - signed accumulator acc, WIDTH+GAIN bits;
  - on each enabled edge, acc <= acc + x - (acc >>> GAIN);
  - the filtered sample is y = acc >>> GAIN, signed WIDTH bits, range ±(2^(WIDTH-1)-1).
  - The shift is arithmetic and floors.
- Square stage: ys^2 and yc^2, each unsigned 2*WIDTH-2 bits.
- Sum: s = ys^2 + yc^2, unsigned 2*WIDTH-1 bits, never overflows.
- Output: out = s >> (WIDTH-1), truncated.
  - Maximum is 2^WIDTH-4, so `out` cannot overflow and needs no saturation.
  - Example: WIDTH=16, both y=32767 gives 65532.
- `en` low freezes the accumulators and all pipeline registers. `out` holds its value.
- Reset clears the accumulators, pipeline registers and `out` to 0.

## Timing
- While `rst` is high, `out` = 0. Reset takes effect immediately, without waiting for a clock edge, including mid-operation.
- Register stages: accumulator -> square register -> `out` register.
  - The `out` register is updated from the sum of the squares.
  - Latency from an accumulator update to `out` is 2 enabled cycles; a third stage is added under the macro below.
- Filter settling: error decays by (1-2^-GAIN) per enabled cycle.
  - With GAIN=8, a full-scale step settles within 0.1% in 2048 enabled cycles.
- Ripple on a zero-mean stream is about ±2^(WIDTH-1-GAIN) on y.
- No handshake: `out` is a continuously updated level, valid at every enabled cycle after settling.

## Configuration
- SD_DUAL_MAG_PIPE_EN defined: an extra register stage sits between the square stage and the adder. Latency to `out` is 3 enabled cycles, for timing closure at high clock rates.
- SD_DUAL_MAG_PIPE_EN undefined: the sum is computed combinationally from the square registers into `out`. Latency is 2 enabled cycles.
- Results are bit-identical in both builds apart from the one-cycle shift.

## Structure
- Shared package sd_dsp_pkg:
  - helper constants for the full-scale code 2^(WIDTH-1)-1;
  - an accumulator width function WIDTH+GAIN.
- One sub-module, sd_small_lpf (parameters WIDTH, GAIN), instantiated twice.
  - It contains the bit mapping and the leaky integrator and outputs y.
- Top level: squares, adder, pipeline and `out` register.

## Test plan
All scenarios use WIDTH=16, GAIN=8.
- Reset: assert `rst` asynchronously mid-stream -> `out`=0 immediately with no clock edge; after release with both inputs held at 0, `out` ramps toward 65532.
- Both inputs constant 1 for 4096 enabled cycles -> ys=yc=32767, `out`=65532 exactly.
- inSin constant 1, inCos alternating 1/0, 4096 cycles -> `out` within 32766 ±300.
- Both inputs alternating 1/0 -> `out` ≤ 2 after settling.
- Enable gating: settle to 65532, drop `en` for 100 cycles while driving inputs to 0 -> `out` stays 65532; raise `en` -> `out` begins moving again.
- Quadrature sweep: two second-order sigma-delta modulators driven with amplitude 30000 sin/cos at a 128-sample period, 64 clocks per sample -> sqrt(`out`·2^15) within 2% of 30000 after settling; repeat the check under both macro settings.
